// File: rtl/nco_lut_loader.sv
// Double-buffered NCO LUT loader: streams a full table into the inactive bank, then swaps banks.
// Optional trailing checksum word gated by the NCO_LUT_CHECKSUM_EN macro.
module nco_lut_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_start,
  input  logic                  load_abort,
  input  logic [15:0]           s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  lut_we,
  output logic [ADDR_WIDTH:0]   lut_waddr,
  output logic [DATA_WIDTH-1:0] lut_wdata,
  output logic                  active_bank,
  output logic                  busy,
  output logic                  load_done,
  output logic                  load_err
);

`ifdef NCO_LUT_CHECKSUM_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_LOAD = 2'd1, ST_COMMIT = 2'd2, ST_CHECK = 2'd3} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_LOAD = 2'd1, ST_COMMIT = 2'd2} state_t;
`endif

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic                  r_we;
  logic [ADDR_WIDTH:0]   r_waddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_bank;
  logic                  r_done;
  logic                  r_err;
  logic                  w_ready;
  logic                  w_beat;
  logic                  w_last;
`ifdef NCO_LUT_CHECKSUM_EN
  logic [15:0]           r_sum;
  logic                  w_ck_bad;
`endif

  generate
    if (DATA_WIDTH < 16) begin : g_hi_bits
      logic w_unused_hi;
      assign w_unused_hi = ^s_data[15:DATA_WIDTH];
    end
  endgenerate

  assign w_beat = s_valid && w_ready;
  assign w_last = (r_cnt == '1);
`ifdef NCO_LUT_CHECKSUM_EN
  assign w_ck_bad = (s_data != r_sum);
`endif

  // Abort has priority over an offered beat, so it also masks s_ready.
  always_comb begin
    w_ready = 1'b0;
    if (r_state == ST_LOAD)
      w_ready = !load_abort;
`ifdef NCO_LUT_CHECKSUM_EN
    if (r_state == ST_CHECK)
      w_ready = !load_abort;
`endif
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (load_start) w_next = ST_LOAD;
      ST_LOAD: begin
        if (load_abort)
          w_next = ST_IDLE;
        else if (w_beat && w_last)
`ifdef NCO_LUT_CHECKSUM_EN
          w_next = ST_CHECK;
`else
          w_next = ST_COMMIT;
`endif
      end
`ifdef NCO_LUT_CHECKSUM_EN
      ST_CHECK: begin
        if (load_abort)
          w_next = ST_IDLE;
        else if (w_beat)
          w_next = w_ck_bad ? ST_IDLE : ST_COMMIT;
      end
`endif
      ST_COMMIT: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_bank  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
`ifdef NCO_LUT_CHECKSUM_EN
      r_sum   <= '0;
`endif
    end else begin
      r_state <= w_next;
      r_we    <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (load_start) begin
            r_cnt <= '0;
            r_err <= 1'b0;
`ifdef NCO_LUT_CHECKSUM_EN
            r_sum <= '0;
`endif
          end
        end
        ST_LOAD: begin
          if (load_abort) begin
            r_err <= 1'b1;
          end else if (w_beat) begin
            r_we    <= 1'b1;
            r_waddr <= {~r_bank, r_cnt};
            r_wdata <= s_data[DATA_WIDTH-1:0];
            r_cnt   <= r_cnt + 1'b1;
`ifdef NCO_LUT_CHECKSUM_EN
            r_sum   <= r_sum + s_data;
`endif
          end
        end
`ifdef NCO_LUT_CHECKSUM_EN
        ST_CHECK: begin
          if (load_abort || (w_beat && w_ck_bad))
            r_err <= 1'b1;
        end
`endif
        // Bank flips on the edge after the last write was issued.
        ST_COMMIT: begin
          r_bank <= ~r_bank;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign s_ready     = w_ready;
  assign lut_we      = r_we;
  assign lut_waddr   = r_waddr;
  assign lut_wdata   = r_wdata;
  assign active_bank = r_bank;
  assign busy        = (r_state != ST_IDLE);
  assign load_done   = r_done;
  assign load_err    = r_err;

endmodule

// File: tb/tb_nco_lut_loader.sv
// Scoreboard bench for nco_lut_loader: stimulus queues expected writes/status, a monitor compares.
module tb_nco_lut_loader;
  localparam int AW    = 10;
  localparam int DW    = 12;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_start;
  logic          load_abort;
  logic [15:0]   s_data;
  logic          s_valid;
  logic          s_ready;
  logic          lut_we;
  logic [AW:0]   lut_waddr;
  logic [DW-1:0] lut_wdata;
  logic          active_bank;
  logic          busy;
  logic          load_done;
  logic          load_err;

  always #5 clk = ~clk;

  nco_lut_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_abort(load_abort),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
    .active_bank(active_bank), .busy(busy), .load_done(load_done), .load_err(load_err)
  );

  typedef struct {
    string    name;
    logic [4:0] exp;   // {active_bank, busy, load_done, load_err, s_ready}
    bit       bus;     // also require write bus all zero
  } stat_t;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [22:0]   q_wr[$];
  logic          q_done[$];
  stat_t         q_stat[$];
  logic          exp_bank;
  bit            end_req = 1'b0;

  function automatic void exp_stat(string nm, logic b, logic bz, logic d, logic e, logic r, bit bus);
    stat_t s;
    s.name = nm;
    s.exp  = {b, bz, d, e, r};
    s.bus  = bus;
    q_stat.push_back(s);
  endfunction

  // Monitor: samples 1 ns after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (lut_we) begin
        n_cmp++;
        if (q_wr.size() == 0) begin
          n_bad++;
          $display("FAIL write: got unexpected write %h/%h, want none", lut_waddr, lut_wdata);
        end else begin
          logic [22:0] e;
          e = q_wr.pop_front();
          if ({lut_waddr, lut_wdata} !== e) begin
            n_bad++;
            $display("FAIL write: got addr %h data %h, want addr %h data %h",
                     lut_waddr, lut_wdata, e[22:12], e[11:0]);
          end
        end
      end
      if (load_done) begin
        n_cmp++;
        if (q_done.size() == 0) begin
          n_bad++;
          $display("FAIL load_done: got unexpected pulse, want none");
        end else begin
          logic eb;
          eb = q_done.pop_front();
          if (active_bank !== eb) begin
            n_bad++;
            $display("FAIL done_bank: got %b, want %b", active_bank, eb);
          end
        end
      end
      while (q_stat.size() > 0) begin
        stat_t s;
        s = q_stat.pop_front();
        n_cmp++;
        if ({active_bank, busy, load_done, load_err, s_ready} !== s.exp) begin
          n_bad++;
          $display("FAIL %s: got bank/busy/done/err/ready %b, want %b", s.name,
                   {active_bank, busy, load_done, load_err, s_ready}, s.exp);
        end
        if (s.bus) begin
          n_cmp++;
          if ({lut_we, lut_waddr, lut_wdata} !== 24'h0) begin
            n_bad++;
            $display("FAIL %s_bus: got we %b addr %h data %h, want all zero", s.name,
                     lut_we, lut_waddr, lut_wdata);
          end
        end
      end
      if (end_req) begin
        n_cmp++;
        if (q_wr.size() != 0 || q_done.size() != 0) begin
          n_bad++;
          $display("FAIL drain: got %0d writes / %0d done pending, want 0 / 0",
                   q_wr.size(), q_done.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got no end of run, want finish before 1 ms");
    $fatal(1, "timeout");
  end

  task automatic start_load(input bit with_abort);
    load_start = 1'b1;
    load_abort = with_abort;
    exp_stat("start", exp_bank, 1'b1, 1'b0, 1'b0, !with_abort, 1'b0);
    @(negedge clk);
    load_start = 1'b0;
    load_abort = 1'b0;
  endtask

  task automatic send_beat(input logic [15:0] d, input bit toggle, input bit expect_wr, input int idx);
    logic [AW-1:0] a;
    a = idx[AW-1:0];
    if (toggle) begin
      s_valid = 1'b0;
      @(negedge clk);
    end
    s_valid = 1'b1;
    s_data  = d;
    if (expect_wr) q_wr.push_back({~exp_bank, a, d[DW-1:0]});
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  // pattern 0: d=i; 1: d=3i (beat 5 = 0xF123, load_start at beat 10); 2: d=1
  task automatic load_table(input bit toggle, input int pattern, input bit with_abort, input bit bad_ck);
    logic [15:0] d;
`ifdef NCO_LUT_CHECKSUM_EN
    logic [15:0] sum;
    sum = '0;
`endif
    start_load(with_abort);
    for (int i = 0; i < DEPTH; i++) begin
      case (pattern)
        1:       d = (i == 5) ? 16'hF123 : 16'((i * 3) & 32'h0FFF);
        2:       d = 16'h0001;
        default: d = 16'(i);
      endcase
      if (pattern == 1 && i == 10) load_start = 1'b1;
`ifdef NCO_LUT_CHECKSUM_EN
      sum = sum + d;
`endif
      send_beat(d, toggle, 1'b1, i);
      load_start = 1'b0;
    end
`ifdef NCO_LUT_CHECKSUM_EN
    send_beat(bad_ck ? sum + 16'd1 : sum, toggle, 1'b0, 0);
`endif
    if (!bad_ck) begin
      exp_bank = ~exp_bank;
      q_done.push_back(exp_bank);
      exp_stat("commit", exp_bank, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      exp_stat("after_commit", exp_bank, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
    end else begin
      exp_stat("ck_err", exp_bank, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
    end
  endtask

  task automatic partial_load(input int n, input bit do_abort);
    start_load(1'b0);
    for (int i = 0; i < n; i++)
      send_beat(16'(i + 32'h100), 1'b0, 1'b1, i);
    if (do_abort) begin
      s_valid    = 1'b1;
      s_data     = 16'h0ABC;
      load_abort = 1'b1;
      exp_stat("abort", exp_bank, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      s_valid    = 1'b0;
      load_abort = 1'b1;
      exp_stat("err_sticky", exp_bank, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      load_abort = 1'b0;
    end else begin
      rst_n    = 1'b0;
      exp_bank = 1'b0;
      exp_stat("mid_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    load_start = 1'b0;
    load_abort = 1'b0;
    s_data     = '0;
    s_valid    = 1'b0;
    exp_bank   = 1'b0;
    @(negedge clk);
    exp_stat("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    load_table(1'b0, 0, 1'b1, 1'b0);   // start+abort together, bank 0->1
    load_table(1'b1, 1, 1'b0, 1'b0);   // gapped stream, masking, ignored restart, bank 1->0
    partial_load(500, 1'b1);           // abort at beat 500
    load_table(1'b0, 0, 1'b0, 1'b0);   // clears err, bank 0->1
    partial_load(300, 1'b0);           // reset mid-load, bank back to 0
    load_table(1'b0, 0, 1'b0, 1'b0);   // bank 0->1
`ifdef NCO_LUT_CHECKSUM_EN
    load_table(1'b0, 2, 1'b0, 1'b0);   // checksum 0x0400 good
    load_table(1'b0, 2, 1'b0, 1'b1);   // checksum 0x0401 bad
`endif
    repeat (3) @(negedge clk);
    end_req = 1'b1;
  end

endmodule

// File: doc/nco_lut_loader.md
Name: nco_lut_loader

Overview:
- Loads a new sine/waveform table into a double-buffered NCO LUT RAM from a host word stream (FMC FIFO read side).
- Writes the full table into the inactive bank. On successful completion, atomically swaps the active bank, so the NCO reader never sees a partially written table.
- Sits between the FMC FIFO output and the write port of the NCO LUT RAM. The NCO read path takes `active_bank` as its address MSB.

Parameters:
- ADDR_WIDTH, 10, log2 of table depth; one table = 1<<ADDR_WIDTH samples.
- DATA_WIDTH, 12, sample width written to the LUT; must be <= 16.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- load_start  in  1  single-cycle request to begin loading a table.
- load_abort  in  1  single-cycle request to cancel a load in progress.
- s_data  in  16  host stream word; sample in bits [DATA_WIDTH-1:0].
- s_valid  in  1  s_data valid.
- s_ready  out  1  loader accepts s_data this cycle.
- lut_we  out  1  LUT RAM write enable.
- lut_waddr  out  ADDR_WIDTH+1  write address, MSB = bank.
- lut_wdata  out  DATA_WIDTH  write data.
- active_bank  out  1  bank the NCO reads from.
- busy  out  1  high while not IDLE.
- load_done  out  1  one-cycle pulse on successful commit.
- load_err  out  1  sticky error flag; cleared by the next accepted load_start.

Behaviour:
- Reset values: s_ready=0, lut_we=0, lut_waddr=0, lut_wdata=0, active_bank=0, busy=0, load_done=0, load_err=0, state=IDLE, word counter=0.
- States: IDLE -> LOAD -> (CHECK, only with the optional feature) -> COMMIT -> IDLE.
- IDLE:
  - s_ready=0.
  - load_start=1 moves to LOAD, clears the counter and load_err, and sets busy.
- LOAD:
  - s_ready=1 combinationally while in LOAD.
  - A beat transfers when s_valid && s_ready.
  - Each beat registers lut_we=1, lut_waddr={~active_bank, cnt}, lut_wdata=s_data[DATA_WIDTH-1:0] on the same edge. Write appears one cycle after the accepting edge; 1 cycle latency.
  - Upper bits s_data[15:DATA_WIDTH] are ignored.
  - cnt increments per beat. After the beat with cnt=(1<<ADDR_WIDTH)-1: go to COMMIT, or to CHECK if the feature is enabled. cnt wraps to 0.
  - s_valid low stalls the load with no timeout; lut_we=0 on those cycles.
- COMMIT (one cycle):
  - active_bank toggles, load_done pulses 1 for exactly one cycle, then return to IDLE with busy=0.
  - The final lut_we is issued on the cycle COMMIT is entered. The swap takes effect on the edge after it, so the final write lands before the reader switches.
- load_abort:
  - Honoured in LOAD or CHECK: go to IDLE, set load_err=1, no swap, active bank untouched.
  - A beat presented in the same cycle is not accepted (abort has priority; s_ready forced 0).
  - Ignored in IDLE/COMMIT.
- load_start while busy is ignored. load_start and load_abort together in IDLE: start wins.
- Reset mid-load: all state returns to reset values, including active_bank=0.

Optional Feature:
- Macro: NCO_LUT_CHECKSUM_EN.
- Defined:
  - After the last sample, the loader enters CHECK, keeps s_ready=1 and accepts exactly one extra word.
  - That word is compared with a running 16-bit modular sum of the full 16-bit s_data of all table beats (the sum is cleared on load start).
  - Match: go to COMMIT.
  - Mismatch: load_err=1, no swap, go to IDLE, no load_done.
  - The checksum word is never written to the LUT.
- Not defined: no CHECK state or sum register; LOAD goes directly to COMMIT.

Test Plan (ADDR_WIDTH=10, DATA_WIDTH=12):
- Reset, then load_start and 1024 beats of 0x0000..0x03FF with s_valid held high -> lut_we high 1024 cycles, lut_waddr 0x400..0x7FF, wdata=index, load_done single pulse, active_bank 0->1, busy low afterwards.
- Second load with s_valid toggling every other cycle -> writes to 0x000..0x3FF only on accepted beats, no gaps/duplicates, active_bank 1->0.
- Abort after 500 beats with s_valid=1 that cycle -> beat 500 not written, load_err=1, active_bank unchanged, load_done never pulses; next load_start clears load_err.
- Beat with s_data=0xF123 -> lut_wdata=0x123; load_start during LOAD is ignored (counter not reset).
- NCO_LUT_CHECKSUM_EN defined: 1024 beats of 0x0001 then checksum 0x0400 -> commit and swap. Repeat with 0x0401 -> load_err=1, no swap, no load_done.
- Assert rst_n mid-LOAD at beat 300 -> all outputs return to reset values immediately; a new full load then completes normally into bank 1.
